// File: rtl/depacketizer.sv
// depacketizer: finds the BPSK preamble/sync header, decodes mode and length, emits the payload as AXIS
//   clk, rst                  symbol clock, synchronous active-high reset
//   MODE_CTRL                 0100 enables deframing, any other value is a registered passthrough
//   in_tdata/tvalid/tuser/tlast   demodulated symbol stream (in_tdata[0] is the header bit)
//   out_tdata/tvalid/tready/tlast/tuser   payload stream, tuser = is_bpsk
//   pkt_len, pkt_len_vld      decoded length in bits and its update pulse
//   hdr_err, ovf, busy        header failure pulse, dropped-beat pulse, not-hunting flag
module depacketizer #(
  parameter int BYTES   = 1,
  parameter int MIN_PRE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         MODE_CTRL,
  input  logic [BYTES*8-1:0] in_tdata,
  input  logic               in_tvalid,
  input  logic               in_tuser,
  input  logic               in_tlast,
  output logic [BYTES*8-1:0] out_tdata,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic               out_tlast,
  output logic               out_tuser,
  output logic [15:0]        pkt_len,
  output logic               pkt_len_vld,
  output logic               hdr_err,
  output logic               ovf,
  output logic               busy
);
  localparam logic [2:0] HUNT = 3'd0, PRE = 3'd1, SYNC = 3'd2, MODE = 3'd3, LEN = 3'd4, PAD = 3'd5, PLD = 3'd6;
  logic [2:0]         r_state;
  logic               r_prev_b, r_is_bpsk, r_from_pld;
  logic [7:0]         r_alt_cnt;
  logic [15:0]        r_cnt, r_len, r_nsym;
  logic [3:0]         r_match;
  logic [BYTES*8-1:0] r_tdata;
  logic               r_tvalid, r_tlast, r_tuser, r_len_vld, r_hdr_err;
  logic [15:0]        r_pkt_len;
  logic               w_mix, w_b, w_alt, w_last;
  logic [3:0]         w_match_tot;
  logic [15:0]        w_len, w_nsym;
  assign w_mix       = MODE_CTRL == 4'b0100;
  assign w_b         = in_tdata[0];
  assign w_alt       = w_b != r_prev_b;
  // mode reference pattern is 1,0,1,0,... so the expected bit is the inverse of the index LSB
  assign w_match_tot = r_match + {3'd0, w_b == ~r_cnt[0]};
  assign w_len       = {r_len[14:0], w_b};
  assign w_nsym      = r_is_bpsk ? w_len : w_len >> 1;
  assign w_last      = r_cnt == r_nsym - 16'd1;
  assign out_tdata   = r_tdata;
  assign out_tvalid  = r_tvalid;
  assign out_tlast   = r_tlast;
  assign out_tuser   = r_tuser;
  assign pkt_len     = r_pkt_len;
  assign pkt_len_vld = r_len_vld;
  assign hdr_err     = r_hdr_err;
  // a payload beat presented while downstream stalls is lost, flagged in the same cycle
  assign ovf         = r_from_pld & ~out_tready;
  assign busy        = r_state != HUNT;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_prev_b   <= 1'b0;
      r_is_bpsk  <= 1'b1;
      r_from_pld <= 1'b0;
      r_alt_cnt  <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_nsym     <= '0;
      r_match    <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b1;
      r_pkt_len  <= '0;
      r_len_vld  <= 1'b0;
      r_hdr_err  <= 1'b0;
    end else begin
      r_len_vld  <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_from_pld <= 1'b0;
      if (!w_mix) begin
        r_tdata   <= in_tdata;
        r_tvalid  <= in_tvalid;
        r_tlast   <= in_tlast;
        r_tuser   <= in_tuser;
        r_state   <= HUNT;
        r_alt_cnt <= '0;
        r_cnt     <= '0;
        r_match   <= '0;
      end else begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        if (in_tvalid) begin
          r_prev_b <= w_b;
          case (r_state)
            HUNT: begin
              r_alt_cnt <= w_alt ? r_alt_cnt + 8'd1 : 8'd0;
              if (w_alt && r_alt_cnt == 8'(MIN_PRE - 2)) begin
                r_state   <= PRE;
                r_alt_cnt <= '0;
              end
            end
            PRE: if (!w_alt) begin
              r_state <= SYNC;
              r_cnt   <= 16'd1;
            end
            SYNC: begin
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt == 16'd31) begin
                r_state <= MODE;
                r_cnt   <= '0;
                r_match <= '0;
              end
            end
            MODE: begin
              r_match <= w_match_tot;
              r_cnt   <= r_cnt + 16'd1;
              if (r_cnt == 16'd7) begin
                r_cnt     <= '0;
                r_match   <= '0;
                r_is_bpsk <= w_match_tot >= 4'd5;
                r_hdr_err <= w_match_tot == 4'd4;
                r_state   <= w_match_tot == 4'd4 ? HUNT : LEN;
              end
            end
            LEN: begin
              r_len <= w_len;
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt == 16'd15) begin
                r_cnt     <= '0;
                r_pkt_len <= w_len;
                r_len_vld <= 1'b1;
                r_nsym    <= w_nsym;
                r_hdr_err <= w_nsym == 16'd0;
                r_state   <= w_nsym == 16'd0 ? HUNT : PAD;
              end
            end
            PAD: begin
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt == 16'd39) begin
                r_cnt   <= '0;
                r_state <= PLD;
              end
            end
            PLD: begin
              r_tvalid   <= 1'b1;
              r_from_pld <= 1'b1;
              r_tdata    <= in_tdata;
              r_tuser    <= r_is_bpsk;
              r_tlast    <= w_last;
              r_cnt      <= w_last ? 16'd0 : r_cnt + 16'd1;
              r_state    <= w_last ? HUNT : PLD;
            end
            default: r_state <= HUNT;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_depacketizer.sv
// tb_depacketizer: directed header/payload sequences for the depacketizer
module tb_depacketizer;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  mode_ctrl = 4'b0100;
  logic [7:0]  in_tdata = '0;
  logic        in_tvalid = 1'b0, in_tuser = 1'b0, in_tlast = 1'b0, out_tready = 1'b1;
  logic [7:0]  out_tdata;
  logic        out_tvalid, out_tlast, out_tuser, pkt_len_vld, hdr_err, ovf, busy;
  logic [15:0] pkt_len;
  int          checks = 0, errors = 0;
  int          vld_n = 0, err_n = 0, ovf_n = 0, beat_n = 0;
  int          v0, e0, o0, b0;
  logic [15:0] seen_len = '0;
  localparam logic [7:0] M_BPSK = 8'b10101010, M_QPSK = 8'b01010101, M_BAD = 8'b10100101;
  always #5 clk = ~clk;
  depacketizer #(.BYTES(1), .MIN_PRE(32)) dut (
    .clk(clk), .rst(rst), .MODE_CTRL(mode_ctrl),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tuser(out_tuser), .pkt_len(pkt_len), .pkt_len_vld(pkt_len_vld),
    .hdr_err(hdr_err), .ovf(ovf), .busy(busy)
  );
  always @(negedge clk) begin
    if (pkt_len_vld) begin
      vld_n++;
      seen_len = pkt_len;
    end
    if (hdr_err) err_n++;
    if (ovf) ovf_n++;
    if (out_tvalid) beat_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sym(input logic [7:0] d);
    in_tdata  = d;
    in_tvalid = 1'b1;
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic header(input logic [7:0] m, input logic [15:0] len);
    for (int i = 0; i < 224; i++) sym(8'(i % 2));
    for (int i = 0; i < 32; i++) sym(8'((i + 1) % 2));
    for (int i = 0; i < 8; i++) sym({7'd0, m[7-i]});
    for (int i = 0; i < 16; i++) sym({7'd0, len[15-i]});
    for (int i = 0; i < 40; i++) sym(8'd0);
  endtask
  task automatic beat(input string tag, input logic [7:0] d, input logic tl, input logic tu);
    sym(d);
    chk({tag, "_tvalid"}, out_tvalid, 1);
    chk({tag, "_tdata"}, out_tdata, d);
    chk({tag, "_tlast"}, out_tlast, tl);
    chk({tag, "_tuser"}, out_tuser, tu);
  endtask
  task automatic snap();
    v0 = vld_n; e0 = err_n; o0 = ovf_n; b0 = beat_n;
  endtask
  initial begin
    idle(3);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tuser", out_tuser, 1);
    chk("rst_tlast", out_tlast, 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_flags", {pkt_len_vld, hdr_err, ovf, busy}, 0);
    rst = 1'b0;
    idle(2);
    snap();
    header(M_BPSK, 16'd5);
    chk("t1_vld", vld_n - v0, 1);
    chk("t1_len", seen_len, 5);
    chk("t1_busy_pld", busy, 1);
    beat("t1_b1", 8'd1, 0, 1);
    beat("t1_b2", 8'd0, 0, 1);
    beat("t1_b3", 8'd1, 0, 1);
    beat("t1_b4", 8'd1, 0, 1);
    beat("t1_b5", 8'd0, 1, 1);
    chk("t1_busy_end", busy, 0);
    idle(1);
    chk("t1_tvalid_after", out_tvalid, 0);
    chk("t1_beats", beat_n - b0, 5);
    snap();
    header(M_QPSK, 16'd8);
    chk("t2_len", seen_len, 8);
    beat("t2_b1", 8'd0, 0, 0);
    beat("t2_b2", 8'd1, 0, 0);
    beat("t2_b3", 8'd2, 0, 0);
    beat("t2_b4", 8'd3, 1, 0);
    idle(1);
    chk("t2_beats", beat_n - b0, 4);
    snap();
    header(M_BPSK, 16'd1);
    beat("t3_b1", 8'd1, 1, 1);
    chk("t3_busy", busy, 0);
    idle(1);
    snap();
    header(M_BPSK, 16'd0);
    idle(2);
    chk("t3_len0_err", err_n - e0, 1);
    chk("t3_len0_vld", vld_n - v0, 1);
    chk("t3_len0_pkt_len", seen_len, 0);
    chk("t3_len0_beats", beat_n - b0, 0);
    chk("t3_len0_busy", busy, 0);
    snap();
    header(M_BAD, 16'd5);
    idle(2);
    chk("t4_err", err_n - e0, 1);
    chk("t4_no_vld", vld_n - v0, 0);
    chk("t4_busy", busy, 0);
    header(M_BPSK, 16'd2);
    chk("t4_len", seen_len, 2);
    beat("t4_b1", 8'h11, 0, 1);
    beat("t4_b2", 8'h22, 1, 1);
    idle(1);
    snap();
    header(M_BPSK, 16'd4);
    beat("t5_b1", 8'hA1, 0, 1);
    idle(1);
    out_tready = 1'b0;
    sym(8'hA2);
    chk("t5_ovf", ovf, 1);
    chk("t5_lost_tlast", out_tlast, 0);
    idle(1);
    out_tready = 1'b1;
    beat("t5_b3", 8'hA3, 0, 1);
    idle(1);
    beat("t5_b4", 8'hA4, 1, 1);
    idle(1);
    chk("t5_ovf_cnt", ovf_n - o0, 1);
    chk("t5_busy", busy, 0);
    header(M_BPSK, 16'd6);
    beat("t6_b1", 8'h61, 0, 1);
    in_tdata  = 8'h62;
    in_tvalid = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_tvalid = 1'b0;
    chk("t6_rst_tvalid", out_tvalid, 0);
    chk("t6_rst_tlast", out_tlast, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pkt_len", pkt_len, 0);
    snap();
    for (int i = 3; i <= 6; i++) sym(8'(8'h60 + i));
    idle(1);
    chk("t6_no_beats", beat_n - b0, 0);
    header(M_BPSK, 16'd3);
    chk("t6_len", seen_len, 3);
    beat("t6_n1", 8'h71, 0, 1);
    beat("t6_n2", 8'h72, 0, 1);
    beat("t6_n3", 8'h73, 1, 1);
    idle(1);
    mode_ctrl = 4'b0001;
    in_tdata  = 8'hA5;
    in_tvalid = 1'b1;
    in_tlast  = 1'b1;
    in_tuser  = 1'b0;
    @(posedge clk);
    #1;
    chk("pt_tdata", out_tdata, 8'hA5);
    chk("pt_ctrl", {out_tvalid, out_tlast, out_tuser}, 3'b110);
    in_tdata  = 8'h3C;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b1;
    @(posedge clk);
    #1;
    chk("pt_tdata2", out_tdata, 8'h3C);
    chk("pt_ctrl2", {out_tvalid, out_tlast, out_tuser}, 3'b001);
    chk("pt_flags", {pkt_len_vld, hdr_err, ovf, busy}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/depacketizer.md
Name: depacketizer

Overview:
- Receive-side counterpart of the TX packetizer. It consumes the demodulated symbol stream at the slow symbol clock and finds the BPSK header: an alternating preamble followed by a phase-reversal sync word.
- It decodes the modulation flag and the 16-bit payload length, strips the header, and emits the payload as AXIS with tlast on the final symbol.
- It sits between the symbol slicer/demodulator and the receive FIFO.

Parameters:
- BYTES, 1, AXIS data width in bytes; BITS = BYTES*8.
- MIN_PRE, 32, consecutive alternating symbols required before a reversal is accepted (range 8..223).

Ports:
- clk  in  1  symbol clock (1.024 MHz).
- rst  in  1  synchronous active-high reset.
- MODE_CTRL  in  4  0001 BPSK, 0010 QPSK, 0100 MIX. Only MIX enables deframing.
- in_tdata  in  BITS  demodulated symbol; in_tdata[0] is the hard-decision BPSK bit used during the header.
- in_tvalid  in  1  symbol valid. There is no upstream backpressure.
- in_tuser  in  1  unused in MIX. Passed through in other modes.
- in_tlast  in  1  unused in MIX. Passed through in other modes.
- out_tdata  out  BITS  payload symbol.
- out_tvalid  out  1  payload valid.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  last payload symbol.
- out_tuser  out  1  is_bpsk of the current packet.
- pkt_len  out  16  decoded payload length in bits. Held until the next header.
- pkt_len_vld  out  1  one-cycle pulse when pkt_len is updated.
- hdr_err  out  1  one-cycle pulse on header decode failure.
- ovf  out  1  one-cycle pulse when a payload symbol is dropped.
- busy  out  1  high in any state other than HUNT.

Behaviour:
- Reset:
  - All outputs are 0, except out_tuser = 1.
  - State is HUNT; all counters are 0.
  - Reset mid-packet aborts the packet silently; no tlast is emitted.
- Symbol advance: every counter and state transition advances only on cycles with in_tvalid = 1. in_tvalid = 0 freezes the FSM.
- Non-MIX mode:
  - Registered passthrough: out_* <= in_* with one cycle of latency, including tlast and tuser.
  - hdr_err, ovf and pkt_len_vld are 0.
  - FSM is forced to HUNT.
  - Leaving MIX mid-packet drops the packet.
- Header on air (BPSK, MSB-first fields, 320 symbols total):
  - 224 symbols of alternating 0101….
  - 32 symbols of 1010…; its first symbol repeats the previous 1 (the reversal).
  - 8-symbol mode field: 1010… for BPSK, 0101… for QPSK.
  - 16 length bits.
  - 40 pad symbols.
- FSM states and transitions:
  - HUNT: alt_cnt increments when b != prev_b; otherwise alt_cnt resets to 0. Go to PRE when alt_cnt reaches MIN_PRE-1.
  - PRE: alternation keeps PRE. A repeated symbol (b == prev_b) is the reversal: go to SYNC with sync_cnt = 1.
  - SYNC: skip 31 more symbols without checking them, then go to MODE.
  - MODE: count matches against 1,0,1,0,1,0,1,0.
    - ≥5 matches: is_bpsk = 1.
    - ≤3 matches: is_bpsk = 0.
    - Exactly 4: pulse hdr_err and go to HUNT.
  - LEN: shift in 16 bits, MSB first. At the end:
    - pkt_len is set and pkt_len_vld pulses.
    - nsym = is_bpsk ? len : len >> 1 (16-bit).
    - nsym == 0: pulse hdr_err and go to HUNT.
  - PAD: skip 40 symbols, then go to PLD.
  - PLD: each valid symbol produces an output beat the next cycle:
    - out_tdata = in_tdata, out_tuser = is_bpsk.
    - out_tlast = 1 when pld_cnt == nsym-1; after that beat, go to HUNT.
    - nsym = 1 therefore produces a single beat with tlast set.
- Output handshake:
  - out_tvalid is high exactly one cycle per payload symbol.
  - If out_tready = 0 while out_tvalid = 1, the beat is lost and ovf pulses in the same cycle. The counter still advances, so tlast still occurs on the correct symbol index.
- Latency: one clk from the last payload in_tvalid to out_tlast.
- Errors never leave stale output: out_tvalid = 0 outside PLD.

Test Plan:
- MIX, BPSK header + len=5, 5 payload symbols 1,0,1,1,0, out_tready = 1 → pkt_len_vld pulse with pkt_len = 5; 5 beats with tuser = 1; tlast on the 5th beat; busy drops the next cycle.
- MIX, QPSK mode field, len=8, payload 0,1,2,3 (BYTES=1) → 4 beats 0,1,2,3 with tuser = 0; tlast on the beat with data 3.
- Same as BPSK but len=1 → one beat with tvalid = tlast = 1. Then len=0 → hdr_err pulse, no beats, state HUNT.
- Mode field 1,0,1,0,0,1,0,1 (4 matches) → hdr_err pulse, no pkt_len_vld. A following correct packet is received normally.
- BPSK len=4, in_tvalid toggling 1/0, out_tready = 0 on beat 2 → ovf pulse once; beats 1, 3, 4 delivered; tlast on beat 4.
- rst asserted for one cycle during payload symbol 2 of 6 → outputs 0, no tlast. Next packet decoded correctly. MODE_CTRL = 0001 → in_* appears on out_* after one cycle.
